// File: rtl/req_dispatch.sv
// req_dispatch: pops one request from the FIFO head, runs it on a multi-cycle execution unit, returns a tagged response.
//   clk, rst_b        clock, asynchronous active-low reset
//   fifo_req          FIFO head packet (req=1 means valid head)
//   fifo_read         pop pulse, only while idle
//   exe_start         one-cycle launch pulse; exe_type/exe_op1/exe_op2 hold the captured request
//   exe_done          result-valid pulse; exe_result is valid with it
//   rsp_valid/ready   response handshake; rsp_id/rsp_data/rsp_status held until accepted
//   busy              high whenever not idle
// Optional macro REQ_DISPATCH_TIMEOUT_EN adds an abort after TIMEOUT cycles waiting for exe_done.
package req_dispatch_pkg;
  localparam int TYPE_W = 3;
  localparam int ID_W   = 4;
  localparam int DATA_W = 16;
  typedef struct packed {
    logic              req;
    logic [TYPE_W-1:0] req_type;
    logic [ID_W-1:0]   req_id;
    logic [DATA_W-1:0] req_data1;
    logic [DATA_W-1:0] req_data2;
  } req_pkt_type;
endpackage

module req_dispatch
  import req_dispatch_pkg::*;
#(
  parameter int NUM_TYPES = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  req_pkt_type       fifo_req,
  output logic              fifo_read,
  output logic              exe_start,
  output logic [TYPE_W-1:0] exe_type,
  output logic [DATA_W-1:0] exe_op1,
  output logic [DATA_W-1:0] exe_op2,
  input  logic              exe_done,
  input  logic [DATA_W-1:0] exe_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy
);
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_BAD = 2'b01;
  localparam logic [1:0] ST_TO  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state, w_next;
  logic [TYPE_W-1:0] r_type;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_op1, r_op2, r_rsp_data;
  logic [1:0]        r_status;
  logic              w_type_ok, w_timeout;

  assign w_type_ok = 32'(fifo_req.req_type) < 32'(NUM_TYPES);

`ifdef REQ_DISPATCH_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // Counter indexes the current WAIT cycle; the last allowed one is TIMEOUT-1.
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r_cnt <= '0;
    else if (r_state == ISSUE) r_cnt <= '0;
    else if (r_state == WAIT && !exe_done) r_cnt <= r_cnt + 1'b1;

  assign w_timeout = r_state == WAIT && r_cnt == CNT_W'(TIMEOUT - 1);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    fifo_read = 1'b0;
    exe_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = r_state != IDLE;
    case (r_state)
      IDLE: begin
        fifo_read = fifo_req.req;
        if (fifo_req.req) w_next = w_type_ok ? ISSUE : RESP;
      end
      ISSUE: begin
        exe_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT: if (exe_done || w_timeout) w_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      r_state    <= IDLE;
      r_type     <= '0;
      r_id       <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_rsp_data <= '0;
      r_status   <= ST_OK;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && fifo_req.req) begin
        r_type <= fifo_req.req_type;
        r_id   <= fifo_req.req_id;
        r_op1  <= fifo_req.req_data1;
        r_op2  <= fifo_req.req_data2;
        if (!w_type_ok) begin
          r_rsp_data <= '0;
          r_status   <= ST_BAD;
        end
      end
      // A done in the final allowed WAIT cycle takes priority over the abort.
      if (r_state == WAIT && exe_done) begin
        r_rsp_data <= exe_result;
        r_status   <= ST_OK;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_status   <= ST_TO;
      end
    end

  assign exe_type   = r_type;
  assign exe_op1    = r_op1;
  assign exe_op2    = r_op2;
  assign rsp_id     = r_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_status;
endmodule

// File: tb/tb_req_dispatch.sv
// tb_req_dispatch: randomized scoreboard bench for req_dispatch with FIFO, execution-unit and sink models.
module tb_req_dispatch;
  import req_dispatch_pkg::*;
  localparam int NUM_TYPES = 4;
  localparam int TIMEOUT   = 16;
`ifdef REQ_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0, rst_b = 1'b0;
  req_pkt_type       fifo_req = '0;
  logic              fifo_read, exe_start, rsp_valid, busy;
  logic              exe_done = 1'b0, rsp_ready = 1'b0;
  logic [TYPE_W-1:0] exe_type;
  logic [DATA_W-1:0] exe_op1, exe_op2, rsp_data;
  logic [DATA_W-1:0] exe_result = '0;
  logic [ID_W-1:0]   rsp_id;
  logic [1:0]        rsp_status;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        st;
    int                lat;
  } exp_t;

  exp_t        exp_q[$];
  req_pkt_type fq[$];
  int          lat_q[$];
  int          n_vec = 0, n_err = 0, cyc = 0;

  req_dispatch #(.NUM_TYPES(NUM_TYPES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_b(rst_b), .fifo_req(fifo_req), .fifo_read(fifo_read),
    .exe_start(exe_start), .exe_type(exe_type), .exe_op1(exe_op1), .exe_op2(exe_op2),
    .exe_done(exe_done), .exe_result(exe_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_status(rsp_status), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behaviour of the execution unit attached to the block.
  function automatic logic [DATA_W-1:0] exe_fn(input logic [TYPE_W-1:0] t, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (t)
      3'd0:    return a ^ b;
      3'd1:    return a + b;
      3'd2:    return a - b;
      default: return a & b;
    endcase
  endfunction

  // Queue a packet in the FIFO model and predict its response and its pop-to-valid latency.
  task automatic push(input logic [TYPE_W-1:0] t, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d1,
                      input logic [DATA_W-1:0] d2, input int lat, input bit expect_rsp);
    req_pkt_type p;
    exp_t e;
    p = '{req: 1'b1, req_type: t, req_id: id, req_data1: d1, req_data2: d2};
    fq.push_back(p);
    if (int'(t) >= NUM_TYPES) e = '{id: id, data: '0, st: 2'd1, lat: 1};
    else begin
      lat_q.push_back(lat);
      if (TO_EN && lat >= TIMEOUT) e = '{id: id, data: '0, st: 2'd2, lat: 2 + TIMEOUT};
      else e = '{id: id, data: exe_fn(t, d1, d2), st: 2'd0, lat: 3 + lat};
    end
    if (expect_rsp) exp_q.push_back(e);
  endtask

  task automatic drain(input int max);
    int t = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && t < max) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size() + fq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : fifo_model
    bit pop;
    forever begin
      @(negedge clk);
      pop = rst_b && fifo_read && fifo_req.req;
      @(posedge clk);
      #1;
      if (pop && fq.size() != 0) void'(fq.pop_front());
      fifo_req = fq.size() != 0 ? fq[0] : '0;
    end
  end

  initial begin : sink_model
    forever begin
      @(posedge clk);
      #1 rsp_ready = $urandom_range(0, 4) > 1;
    end
  end

  // Execution unit: stray dones outside a launch, a possible stray in the launch cycle, then the real done.
  initial begin : exe_model
    forever begin
      @(negedge clk);
      if (rst_b && fifo_read && fifo_req.req && int'(fifo_req.req_type) < NUM_TYPES) begin
        int l;
        bit to;
        logic [DATA_W-1:0] res;
        @(posedge clk);
        #1 exe_done = 1'($urandom_range(0, 1));
        exe_result = 16'($urandom);
        @(negedge clk);
        chk("exe_start", exe_start, 1);
        l = lat_q.size() != 0 ? lat_q.pop_front() : 0;
        to = TO_EN && l >= TIMEOUT;
        res = exe_fn(exe_type, exe_op1, exe_op2);
        for (int k = 0; k < (to ? TIMEOUT : l); k++) begin
          @(posedge clk);
          #1 exe_done = 1'b0;
        end
        if (!to) begin
          @(posedge clk);
          #1 exe_done = 1'b1;
          exe_result = res;
        end
        @(posedge clk);
        #1 exe_done = 1'b0;
      end else begin
        @(posedge clk);
        #1 exe_done = $urandom_range(0, 3) == 0;
        exe_result = 16'($urandom);
      end
    end
  end

  initial begin : monitor
    bit held = 0, hs_prev = 0;
    int pop_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        held = 0;
        hs_prev = 0;
      end else begin
        if (hs_prev) chk("idle_after_handshake", busy, 0);
        hs_prev = 0;
        chk("fifo_read", fifo_read, fifo_req.req && !busy);
        if (fifo_read && fifo_req.req) pop_cyc = cyc;
        if (rsp_valid) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
          else begin
            if (!held) chk("rsp_latency", cyc - pop_cyc, exp_q[0].lat);
            chk("rsp_id", rsp_id, exp_q[0].id);
            chk("rsp_data", rsp_data, exp_q[0].data);
            chk("rsp_status", rsp_status, exp_q[0].st);
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              held = 0;
              hs_prev = 1;
            end else held = 1;
          end
        end else if (held) begin
          chk("valid_dropped", rsp_valid, 1);
          held = 0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_exe_start", exe_start, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_exe_op1", exe_op1, 0);
    chk("rst_exe_type", exe_type, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (4) @(negedge clk);
    push(3'd1, 4'd2, 16'd5, 16'd7, 0, 1);
    drain(200);
    push(3'd4, 4'd1, 16'd9, 16'd3, 0, 1);
    drain(200);
    push(3'd0, 4'd3, 16'h1234, 16'h00ff, 2, 1);
    push(3'd2, 4'd4, 16'd100, 16'd1, 0, 1);
    push(3'd7, 4'd5, 16'd1, 16'd1, 0, 1);
    drain(300);
    push(3'd3, 4'd6, 16'hf0f0, 16'hff00, TIMEOUT - 1, 1);
    push(3'd1, 4'd7, 16'd1, 16'd2, TIMEOUT, 1);
    drain(300);
    for (int i = 0; i < 150; i++) begin
      int lat;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      while (fq.size() >= 3) @(negedge clk);
      lat = $urandom_range(0, 9) == 0 ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1) : $urandom_range(0, 5);
      push(3'($urandom_range(0, 5)), 4'($urandom), 16'($urandom), 16'($urandom), lat, 1);
    end
    drain(5000);
    push(3'd2, 4'd9, 16'd100, 16'd30, 10, 0);
    t = 0;
    while (!exe_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reset_launch_seen", exe_start, 1);
    repeat (3) @(negedge clk);
    chk("reset_in_wait", busy, 1);
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_exe_op1", exe_op1, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    push(3'd0, 4'd11, 16'h00aa, 16'h0f0f, 1, 1);
    drain(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/req_dispatch.md
# req_dispatch

Downstream consumer of the input request FIFO: it pops one `req_pkt_type` packet at a time from the FIFO head and launches it on the multi-cycle execution unit through a start/done handshake. It then returns a tagged response through a valid/ready port toward the response path. There is exactly one request in flight; back-pressure reaches the FIFO because the block does not pop while busy.

## Interface
Parameters:
- `NUM_TYPES`, default 4: legal `req_type` values are 0..NUM_TYPES-1; anything else is rejected without execution.
- `TIMEOUT`, default 16: maximum WAIT cycles before abort (used only with the timeout feature).
- `CNT_W`, default `$clog2(TIMEOUT+1)`: width of the timeout counter.

Ports:
- `clk`  in  1  clock; reset `rst_b`, asynchronous, active-low.
- `rst_b`  in  1  asynchronous active-low reset.
- `fifo_req`  in  req_pkt_type  FIFO head packet; `fifo_req.req==1` means a valid head (an empty FIFO presents all-zero).
- `fifo_read`  out  1  pop pulse to the FIFO.
- `exe_start`  out  1  one-cycle launch pulse.
- `exe_type`  out  width of req_type  captured `req_type`.
- `exe_op1`, `exe_op2`  out  width of req_data  captured `req_data1` / `req_data2`.
- `exe_done`  in  1  result-valid pulse from the execution unit.
- `exe_result`  in  width of req_data  result, valid with `exe_done`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_id`  out  width of req_id  tag of the request.
- `rsp_data`  out  width of req_data  result; zero on error.
- `rsp_status`  out  2  00 OK, 01 BAD_TYPE, 10 TIMEOUT.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `fifo_read` is combinationally `fifo_req.req`.
  - On the same edge, the block captures type, id, data1 and data2 into internal registers.
  - If the captured type is below NUM_TYPES, the next state is ISSUE.
  - Otherwise the next state is RESP with status 01 and `rsp_data=0`.
- ISSUE:
  - `exe_start=1` for exactly one cycle; `exe_type/op1/op2` are driven from the captured registers.
  - `exe_done` is ignored in this state.
  - Next state is WAIT.
- WAIT:
  - `exe_start=0`.
  - On `exe_done`, the block registers `exe_result` into `rsp_data` with status 00, and the next state is RESP.
- RESP:
  - `rsp_valid=1`; `rsp_id/rsp_data/rsp_status` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake the next state is IDLE.
  - `rsp_valid` never drops without a handshake.
- `fifo_read` is 0 in every non-IDLE state, so a non-empty FIFO is never popped while busy.
- `exe_done` outside WAIT is discarded. It produces no response and no state change.
- `exe_op1/op2/type` hold their captured values until the next capture; they are not cleared.

## Timing
- Reset values:
  - State IDLE; capture registers 0.
  - `exe_start=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_status=00`, `busy=0`.
  - `fifo_read` follows `fifo_req.req` while in reset-released IDLE.
- Cycle 0: head valid in IDLE; `fifo_read=1`; capture occurs on the edge.
- Cycle 1: `exe_start=1`.
- Cycle 2: earliest `exe_done` is accepted.
- Cycle 3: `rsp_valid=1`.
- With `rsp_ready` held high, the handshake completes in cycle 3 and the next pop occurs in cycle 4. The minimum period is 4 cycles per request.
- BAD_TYPE path: pop in cycle 0, `rsp_valid` in cycle 1, no `exe_start`.
- Reset asserted mid-operation:
  - Immediate return to IDLE; all outputs take their reset values.
  - The in-flight request is dropped.
  - A later `exe_done` for it is discarded by the "outside WAIT" rule once the block is back in IDLE.

## Configuration
- Macro `REQ_DISPATCH_TIMEOUT_EN`.
- Defined:
  - A CNT_W counter clears on entry to WAIT and increments each WAIT cycle without `exe_done`.
  - When it reaches TIMEOUT, the next state is RESP with status 10 and `rsp_data=0`.
  - `exe_done` in the same cycle as the counter reaching TIMEOUT wins, giving status 00.
- Not defined: no counter; WAIT waits indefinitely and status 10 is never produced.

## Test plan
- Single op: head {req=1,type=1,id=2,d1=5,d2=7}, `exe_done` with result 12 in cycle 2, `rsp_ready=1` -> `fifo_read` cycle 0, `exe_start` cycle 1, rsp {id=2,data=12,status=00} in cycle 3.
- Back-pressure: `rsp_ready=0` for 5 cycles with 3 packets in the FIFO -> `rsp_valid` and payload held constant, `fifo_read` stays 0, second pop only on the cycle after the handshake.
- Bad type: type=4 with NUM_TYPES=4, id=1 -> one pop, no `exe_start`, rsp {id=1,data=0,status=01} in cycle 1.
- Stray done: `exe_done=1` in IDLE and in ISSUE -> no `rsp_valid`, state unchanged.
- Timeout (macro on, TIMEOUT=16): `exe_done` never asserted -> rsp {status=10,data=0} 16 WAIT cycles after entry; with `exe_done` on cycle 16 -> status 00.
- Reset mid-WAIT: `rst_b` low for 1 cycle -> `busy=0`, `rsp_valid=0`; a subsequent `exe_done` produces no response; the next FIFO head is popped normally.
